reorder_buffer: RTL

//  Circular reorder buffer that allocates in ID, takes EX/MEM writebacks and retires in order to the register file.

---
 rtl/reorder_buffer_pkg.sv | 32 +++
 rtl/rob_match_finder.sv | 67 ++++++
 rtl/reorder_buffer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared forward-unit defines and types for the reorder buffer slice.
// Optional feature macro used by this slice: ROB_WB_BYPASS_EN (same-cycle writeback bypass).
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef BYPASS_STATE_WIDTH
`define BYPASS_STATE_WIDTH 2
`endif
`ifndef BYPASS_STATE_MISS
`define BYPASS_STATE_MISS 2'd0
`endif
`ifndef BYPASS_STATE_HIT
`define BYPASS_STATE_HIT 2'd1
`endif
`ifndef BYPASS_STATE_WAIT
`define BYPASS_STATE_WAIT 2'd2
`endif
`ifndef ROB_ENTRIES
`define ROB_ENTRIES 8
`endif

package reorder_buffer_pkg;

    localparam int REG_W = 5;

    typedef enum logic [`BYPASS_STATE_WIDTH-1:0] {
        BYP_MISS = `BYPASS_STATE_MISS,
        BYP_HIT  = `BYPASS_STATE_HIT,
        BYP_WAIT = `BYPASS_STATE_WAIT
    } bypass_state_e;

endpackage

// File: rtl/rob_match_finder.sv
// Youngest-match search over the reorder buffer entries for one operand address.
// With ROB_WB_BYPASS_EN defined, a same-cycle writeback to the matching entry is reported as HIT.
module rob_match_finder
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_ENTRIES = `ROB_ENTRIES,
    parameter int TAG_W       = $clog2(ROB_ENTRIES)
) (
    input  logic [ROB_ENTRIES-1:0]         valid,
    input  logic [ROB_ENTRIES-1:0]         ready,
    input  logic [ROB_ENTRIES-1:0]         has_dst,
    input  logic [REG_W-1:0]               dst [ROB_ENTRIES],
    input  logic [`DATA_SIZE-1:0]          value [ROB_ENTRIES],
    input  logic [TAG_W-1:0]               tail,
    input  logic [REG_W-1:0]               addr,
    input  logic                           wb_valid,
    input  logic [TAG_W-1:0]               wb_tag,
    input  logic [`DATA_SIZE-1:0]          wb_value,
    output logic [`BYPASS_STATE_WIDTH-1:0] state,
    output logic [`DATA_SIZE-1:0]          result
);

    logic             found;
    logic [TAG_W-1:0] idx;
    logic [TAG_W-1:0] hit_idx;

    // Walk from tail-1 backwards around the ring; slots outside the window are invalid.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        found   = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int i = 1; i <= ROB_ENTRIES; i++) begin
            idx = tail - TAG_W'(i);
            if (!found && valid[idx] && has_dst[idx] && (dst[idx] == addr)) begin
                found   = 1'b1;
                hit_idx = idx;
            end
        end
    end

    always_comb begin
        state  = BYP_MISS;
        result = '0;
        if ((addr != '0) && found) begin
            if (ready[hit_idx]) begin
                state  = BYP_HIT;
                result = value[hit_idx];
            end
`ifdef ROB_WB_BYPASS_EN
            else if (wb_valid && (wb_tag == hit_idx)) begin
                state  = BYP_HIT;
                result = wb_value;
            end
`endif
            else begin
                state = BYP_WAIT;
            end
        end
    end

`ifndef ROB_WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_tag, wb_value};
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocate in ID, EX/MEM writeback, in-order retirement and operand lookup.
// Optional feature macro: ROB_WB_BYPASS_EN (lookups see a same-cycle writeback as HIT).
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_ENTRIES = `ROB_ENTRIES,
    parameter int TAG_W       = $clog2(ROB_ENTRIES)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           alloc_valid,
    input  logic                           alloc_has_dst,
    input  logic [4:0]                     alloc_dst,
    output logic [TAG_W-1:0]               alloc_tag,
    output logic                           full,
    output logic                           empty,
    input  logic                           wb_valid,
    input  logic [TAG_W-1:0]               wb_tag,
    input  logic [`DATA_SIZE-1:0]          wb_value,
    input  logic [4:0]                     rs_addr,
    input  logic [4:0]                     rt_addr,
    output logic [`BYPASS_STATE_WIDTH-1:0] rs_state,
    output logic [`BYPASS_STATE_WIDTH-1:0] rt_state,
    output logic [`DATA_SIZE-1:0]          rs_value,
    output logic [`DATA_SIZE-1:0]          rt_value,
    output logic                           commit_valid,
    output logic                           commit_we,
    output logic [4:0]                     commit_dst,
    output logic [`DATA_SIZE-1:0]          commit_value
);

    localparam logic [TAG_W:0] ROB_DEPTH = (TAG_W+1)'(ROB_ENTRIES);

    logic [ROB_ENTRIES-1:0] valid_q;
    logic [ROB_ENTRIES-1:0] ready_q;
    logic [ROB_ENTRIES-1:0] has_dst_q;
    logic [REG_W-1:0]       dst_q   [ROB_ENTRIES];
    logic [`DATA_SIZE-1:0]  value_q [ROB_ENTRIES];
    logic [TAG_W-1:0]       head_q;
    logic [TAG_W-1:0]       tail_q;
    logic [TAG_W:0]         count_q;

    logic do_alloc;
    logic do_wb;

    assign full      = (count_q == ROB_DEPTH);
    assign empty     = (count_q == '0);
    assign alloc_tag = tail_q;
    assign do_alloc  = alloc_valid && !full;
    assign do_wb     = wb_valid && valid_q[wb_tag];

    assign commit_valid = valid_q[head_q] && ready_q[head_q];
    assign commit_we    = commit_valid && has_dst_q[head_q] && (dst_q[head_q] != '0);
    assign commit_dst   = commit_valid ? dst_q[head_q] : '0;
    assign commit_value = commit_valid ? value_q[head_q] : '0;

    // Control state. Commit is applied after writeback so a retiring head always ends up cleared.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_wb) begin
                ready_q[wb_tag] <= 1'b1;
            end
            if (commit_valid) begin
                valid_q[head_q] <= 1'b0;
                ready_q[head_q] <= 1'b0;
                head_q          <= head_q + TAG_W'(1);
            end
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                tail_q          <= tail_q + TAG_W'(1);
            end
            count_q <= count_q + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(commit_valid);
        end
    end

    // NOTE: the entry payload is not reset; valid_q gates every use of it, so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            has_dst_q[tail_q] <= alloc_has_dst;
            dst_q[tail_q]     <= alloc_dst;
        end
        if (do_wb) begin
            value_q[wb_tag] <= wb_value;
        end
    end

    rob_match_finder #(
        .ROB_ENTRIES(ROB_ENTRIES),
        .TAG_W      (TAG_W)
    ) u_rs_finder (
        .valid   (valid_q),
        .ready   (ready_q),
        .has_dst (has_dst_q),
        .dst     (dst_q),
        .value   (value_q),
        .tail    (tail_q),
        .addr    (rs_addr),
        .wb_valid(wb_valid),
        .wb_tag  (wb_tag),
        .wb_value(wb_value),
        .state   (rs_state),
        .result  (rs_value)
    );

    rob_match_finder #(
        .ROB_ENTRIES(ROB_ENTRIES),
        .TAG_W      (TAG_W)
    ) u_rt_finder (
        .valid   (valid_q),
        .ready   (ready_q),
        .has_dst (has_dst_q),
        .dst     (dst_q),
        .value   (value_q),
        .tail    (tail_q),
        .addr    (rt_addr),
        .wb_valid(wb_valid),
        .wb_tag  (wb_tag),
        .wb_value(wb_value),
        .state   (rt_state),
        .result  (rt_value)
    );

endmodule
